fma2_stage: RTL
===============

FMA2_STAGE -- requirements
Module: fma2_stage

Interface
REQ-001 Parameter FRAC_WIDTH, default 36, SHALL set the width of the stage-1 result fraction; FW below means FRAC_WIDTH.
REQ-002 Parameter EXP_WIDTH, default 8, SHALL set the width of all signed two's-complement exponents.
REQ-003 i_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_rstn  in  1  SHALL be a synchronous, active-low reset.
REQ-005 i_valid  in  1  SHALL qualify all data and flag inputs in the current cycle.
REQ-006 i_sel_DorX, i_X_ZERO_CAL, i_RESULT_SIGN_FLIP  in  1 each  SHALL be control flags passed through with the data.
REQ-007 i_sign_c / i_exp_c / i_frac_c  in  1 / EXP_WIDTH / FW  SHALL be the stage-1 result c = cof3*X + cof2.
REQ-008 i_sign_XorD / i_exp_XorD / i_frac_XorD  in  1 / EXP_WIDTH / 32  SHALL be the delayed polynomial variable X.
REQ-009 i_sign_cof1 / i_exp_cof1 / i_frac_cof1  in  1 / EXP_WIDTH / FW+4  SHALL be the coefficient added in this stage.
REQ-010 i_sign_cof0 / i_exp_cof0 / i_frac_cof0  in  1 / EXP_WIDTH / FW+4  SHALL be the coefficient carried to the next stage.
REQ-011 o_sign_s / o_exp_s / o_frac_s  out  1 / EXP_WIDTH / FW+4  SHALL carry the result s = c*X + cof1.
REQ-012 o_reg_sign_cof0 / o_reg_exp_cof0 / o_reg_frac_cof0  out  1 / EXP_WIDTH / FW+4  SHALL carry cof0 delayed 2 cycles.
REQ-013 o_sign_XorD / o_exp_XorD / o_frac_XorD  out  1 / EXP_WIDTH / 32  SHALL carry X delayed 2 cycles.
REQ-014 o_sel_DorX, o_X_ZERO_CAL, o_RESULT_SIGN_FLIP  out  1 each  SHALL carry the input flags delayed 2 cycles.
REQ-015 o_valid  out  1  SHALL equal i_valid delayed by exactly 2 cycles.

Function
REQ-016 Number format: value = (-1)^sign * frac * 2^(exp-(W-1)), where W is the fraction width; a nonzero frac SHALL be normalized (MSB=1); frac=0 SHALL mean zero, encoded as sign=0, exp=0.
REQ-017 Stage A (loads when i_valid=1) SHALL form the 68-bit product P = i_frac_c*i_frac_XorD and the sign i_sign_c^i_sign_XorD.
REQ-018 Stage A normalization: if P[67]=1, frac=P[67:28] and exp=ec+ex+1; otherwise frac=P[66:27] and exp=ec+ex; the exponent SHALL be computed at EXP_WIDTH+2 bits; low bits SHALL be truncated.
REQ-019 If either multiplicand frac is 0, the product SHALL be canonical zero.
REQ-020 Stage A SHALL also register cof1, cof0, X and the flags when i_valid=1, and SHALL register valid_1 <= i_valid every cycle.
REQ-021 Stage B (loads when valid_1=1) SHALL align the smaller-exponent operand by right shift with truncation; a shift of 40 or more SHALL make that operand zero.
REQ-022 For equal signs, stage B SHALL add the magnitudes; on carry-out it SHALL shift right by 1 and increment exp.
REQ-023 For unequal signs, stage B SHALL subtract the smaller magnitude from the larger, take the larger operand's sign, and normalize left using a leading-zero count.
REQ-024 An exact-zero sum SHALL output canonical zero.
REQ-025 An exponent above the maximum (127) SHALL saturate to 127 with frac all-ones; an exponent below the minimum (-128) SHALL output canonical zero.
REQ-026 Stage B SHALL register cof0, X and the flags from stage A when valid_1=1; o_valid SHALL be registered from valid_1 every cycle.
REQ-027 There SHALL be no backpressure; registers not enabled SHALL hold their values, and back-to-back valids SHALL give one result per cycle.

Reset
REQ-028 While i_rstn=0 at a clock edge, every output and internal register SHALL clear to 0, overriding the valid enables.
REQ-029 Data in flight during reset SHALL be discarded; no o_valid pulse SHALL result from it.

Structure
REQ-030 The shared fsincos package SHALL hold the FRAC_WIDTH and EXP_WIDTH defaults, the exponent saturation limits, and a float-triple typedef (sign, exp, frac).
REQ-031 The stage-B aligner/adder/normalizer SHALL be one combinational sub-module, fadd_n40; the multiplier SHALL stay inline.

Verification
REQ-032 c=1.0 (frac 0x8_0000_0000, exp 0), X=1.0 (0x8000_0000, exp 0), cof1=1.0 (0x80_0000_0000, exp 0) -> 2 cycles later: o_valid=1, s sign 0, exp 1, frac 0x80_0000_0000.
REQ-033 c=1.0, X=-1.0, cof1=+1.0 -> s is canonical zero (0/0/0).
REQ-034 c=1.5 (0xC_0000_0000), X=1.5 (0xC000_0000), cof1=0 -> s sign 0, exp 1, frac 0x90_0000_0000.
REQ-035 c=X=1.0, cof1 exp 60 -> s equals cof1 bit-exact; c exp 100, X exp 100 -> s exp 127, frac 0xFF_FFFF_FFFF.
REQ-036 i_valid pattern 1,1,0,1 -> o_valid 0,0,1,1,0,1, and pass-through cof0/X/flags match their inputs 2 cycles earlier.
REQ-037 i_rstn=0 one cycle after i_valid=1 -> o_valid stays 0 and all outputs read 0.

Source files
------------

// File: rtl/fsincos_pkg.sv
// Shared definitions for the sin/cos polynomial pipeline: default widths,
// exponent saturation limits and the float-triple record.
package fsincos_pkg;

    localparam int FRAC_WIDTH_DEF = 36;
    localparam int EXP_WIDTH_DEF  = 8;

    // Largest and smallest representable two's-complement exponent for a width
    function automatic int exp_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int exp_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int EXP_SAT_MAX = exp_max(EXP_WIDTH_DEF);
    localparam int EXP_SAT_MIN = exp_min(EXP_WIDTH_DEF);

    // Float triple at the default stage-2 result width (FRAC_WIDTH+4 fraction bits)
    typedef struct packed {
        logic                            sign;
        logic signed [EXP_WIDTH_DEF-1:0] exp;
        logic [FRAC_WIDTH_DEF+3:0]       frac;
    } float_t;

endpackage

// File: rtl/fadd_n40.sv
// Combinational float adder: aligns the smaller operand, adds or subtracts
// magnitudes, renormalizes and saturates the exponent into EW bits.
module fadd_n40
    import fsincos_pkg::*;
#(
    parameter int N   = 40,
    parameter int EW  = 8,
    parameter int EWA = EW + 2
) (
    input  logic                 a_sign_i,
    input  logic signed [EWA-1:0] a_exp_i,
    input  logic [N-1:0]         a_frac_i,
    input  logic                 b_sign_i,
    input  logic signed [EW-1:0] b_exp_i,
    input  logic [N-1:0]         b_frac_i,
    output logic                 s_sign_o,
    output logic signed [EW-1:0] s_exp_o,
    output logic [N-1:0]         s_frac_o
);

    // Internal exponent has headroom for carry increment and a full-width left shift
    localparam int EI   = EWA + 2;
    localparam int RW   = 1 + EW + N;
    localparam int EMAX = exp_max(EW);
    localparam int EMIN = exp_min(EW);

    function automatic int lzc(input logic [N-1:0] v);
        int n;
        n = N;
        for (int k = 0; k < N; k++) begin
            if (v[k]) n = N - 1 - k;
        end
        return n;
    endfunction

    // Zero, overflow and underflow handling of the final triple
    function automatic logic [RW-1:0] saturate(input logic sign,
                                               input logic signed [EI-1:0] e,
                                               input logic [N-1:0] f);
        if (f == '0)  return '0;
        if (e > EMAX) return {sign, EW'(EMAX), {N{1'b1}}};
        if (e < EMIN) return '0;
        return {sign, e[EW-1:0], f};
    endfunction

    logic                 a_big;
    logic signed [EI-1:0] ea, eb, big_e, small_e, diff, e_res;
    logic                 big_s, small_s;
    logic [N-1:0]         big_f, small_f, small_al, dif, f_res;
    logic [N:0]           sum;
    int                   lz;

    // Align, add/subtract, normalize
    always_comb begin
        ea    = {{(EI-EWA){a_exp_i[EWA-1]}}, a_exp_i};
        eb    = {{(EI-EW){b_exp_i[EW-1]}}, b_exp_i};
        // A zero operand never wins, so it cannot pull the exponent away from the other
        a_big = (b_frac_i == '0) ||
                ((a_frac_i != '0) && ((ea > eb) || ((ea == eb) && (a_frac_i >= b_frac_i))));
        big_s   = a_big ? a_sign_i : b_sign_i;
        big_e   = a_big ? ea       : eb;
        big_f   = a_big ? a_frac_i : b_frac_i;
        small_s = a_big ? b_sign_i : a_sign_i;
        small_e = a_big ? eb       : ea;
        small_f = a_big ? b_frac_i : a_frac_i;
        diff    = big_e - small_e;
        if ((small_f == '0) || (diff >= N)) small_al = '0;
        else                                small_al = small_f >> diff;
        sum   = '0;
        dif   = '0;
        lz    = 0;
        f_res = '0;
        e_res = '0;
        if (big_s == small_s) begin
            sum = {1'b0, big_f} + {1'b0, small_al};
            if (sum[N]) begin
                f_res = sum[N:1];
                e_res = big_e + EI'(1);
            end else begin
                f_res = sum[N-1:0];
                e_res = big_e;
            end
        end else begin
            dif   = big_f - small_al;
            lz    = lzc(dif);
            f_res = dif << lz;
            e_res = big_e - EI'(lz);
        end
        {s_sign_o, s_exp_o, s_frac_o} = saturate(big_s, e_res, f_res);
    end

endmodule

// File: rtl/fma2_stage.sv
// Second fused multiply-add stage of the sin/cos polynomial: s = c*X + cof1,
// two-cycle latency, with cof0, X and flags carried alongside.
module fma2_stage
    import fsincos_pkg::*;
#(
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_valid,
    input  logic                        i_sel_DorX,
    input  logic                        i_X_ZERO_CAL,
    input  logic                        i_RESULT_SIGN_FLIP,
    input  logic                        i_sign_c,
    input  logic signed [EXP_WIDTH-1:0] i_exp_c,
    input  logic [FRAC_WIDTH-1:0]       i_frac_c,
    input  logic                        i_sign_XorD,
    input  logic signed [EXP_WIDTH-1:0] i_exp_XorD,
    input  logic [31:0]                 i_frac_XorD,
    input  logic                        i_sign_cof1,
    input  logic signed [EXP_WIDTH-1:0] i_exp_cof1,
    input  logic [FRAC_WIDTH+3:0]       i_frac_cof1,
    input  logic                        i_sign_cof0,
    input  logic signed [EXP_WIDTH-1:0] i_exp_cof0,
    input  logic [FRAC_WIDTH+3:0]       i_frac_cof0,
    output logic                        o_sign_s,
    output logic signed [EXP_WIDTH-1:0] o_exp_s,
    output logic [FRAC_WIDTH+3:0]       o_frac_s,
    output logic                        o_reg_sign_cof0,
    output logic signed [EXP_WIDTH-1:0] o_reg_exp_cof0,
    output logic [FRAC_WIDTH+3:0]       o_reg_frac_cof0,
    output logic                        o_sign_XorD,
    output logic signed [EXP_WIDTH-1:0] o_exp_XorD,
    output logic [31:0]                 o_frac_XorD,
    output logic                        o_sel_DorX,
    output logic                        o_X_ZERO_CAL,
    output logic                        o_RESULT_SIGN_FLIP,
    output logic                        o_valid
);

    localparam int FW = FRAC_WIDTH;
    localparam int EW = EXP_WIDTH;
    localparam int N  = FW + 4;
    localparam int PW = FW + 32;
    localparam int EA = EW + 2;

    logic [PW-1:0]        prod;
    logic signed [EA-1:0] exp_sum;
    logic                 prod_sign_d;
    logic signed [EA-1:0] prod_exp_d;
    logic [N-1:0]         prod_frac_d;

    // Stage A registers
    logic                 vld_p1_q;
    logic                 prod_sign_p1_q;
    logic signed [EA-1:0] prod_exp_p1_q;
    logic [N-1:0]         prod_frac_p1_q;
    logic                 cof1_sign_p1_q, cof0_sign_p1_q, x_sign_p1_q;
    logic signed [EW-1:0] cof1_exp_p1_q, cof0_exp_p1_q, x_exp_p1_q;
    logic [N-1:0]         cof1_frac_p1_q, cof0_frac_p1_q;
    logic [31:0]          x_frac_p1_q;
    logic                 sel_p1_q, xz_p1_q, flip_p1_q;

    // Stage B registers
    logic                 vld_p2_q;
    logic                 s_sign_d, s_sign_p2_q;
    logic signed [EW-1:0] s_exp_d, s_exp_p2_q;
    logic [N-1:0]         s_frac_d, s_frac_p2_q;
    logic                 cof0_sign_p2_q, x_sign_p2_q;
    logic signed [EW-1:0] cof0_exp_p2_q, x_exp_p2_q;
    logic [N-1:0]         cof0_frac_p2_q;
    logic [31:0]          x_frac_p2_q;
    logic                 sel_p2_q, xz_p2_q, flip_p2_q;

    assign prod    = {{32{1'b0}}, i_frac_c} * {{FW{1'b0}}, i_frac_XorD};
    assign exp_sum = {{2{i_exp_c[EW-1]}}, i_exp_c} + {{2{i_exp_XorD[EW-1]}}, i_exp_XorD};

    // Product normalization: keep the top N bits below the leading one, truncate the rest
    always_comb begin
        prod_sign_d = 1'b0;
        prod_exp_d  = '0;
        prod_frac_d = '0;
        if ((i_frac_c != '0) && (i_frac_XorD != '0)) begin
            prod_sign_d = i_sign_c ^ i_sign_XorD;
            if (prod[PW-1]) begin
                prod_frac_d = prod[PW-1 -: N];
                prod_exp_d  = exp_sum + EA'(1);
            end else begin
                prod_frac_d = prod[PW-2 -: N];
                prod_exp_d  = exp_sum;
            end
        end
    end

    // Stage A: capture product and side-band data on valid input
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_p1_q       <= 1'b0;
            prod_sign_p1_q <= 1'b0;
            prod_exp_p1_q  <= '0;
            prod_frac_p1_q <= '0;
            cof1_sign_p1_q <= 1'b0;
            cof1_exp_p1_q  <= '0;
            cof1_frac_p1_q <= '0;
            cof0_sign_p1_q <= 1'b0;
            cof0_exp_p1_q  <= '0;
            cof0_frac_p1_q <= '0;
            x_sign_p1_q    <= 1'b0;
            x_exp_p1_q     <= '0;
            x_frac_p1_q    <= '0;
            sel_p1_q       <= 1'b0;
            xz_p1_q        <= 1'b0;
            flip_p1_q      <= 1'b0;
        end else begin
            vld_p1_q <= i_valid;
            if (i_valid) begin
                prod_sign_p1_q <= prod_sign_d;
                prod_exp_p1_q  <= prod_exp_d;
                prod_frac_p1_q <= prod_frac_d;
                cof1_sign_p1_q <= i_sign_cof1;
                cof1_exp_p1_q  <= i_exp_cof1;
                cof1_frac_p1_q <= i_frac_cof1;
                cof0_sign_p1_q <= i_sign_cof0;
                cof0_exp_p1_q  <= i_exp_cof0;
                cof0_frac_p1_q <= i_frac_cof0;
                x_sign_p1_q    <= i_sign_XorD;
                x_exp_p1_q     <= i_exp_XorD;
                x_frac_p1_q    <= i_frac_XorD;
                sel_p1_q       <= i_sel_DorX;
                xz_p1_q        <= i_X_ZERO_CAL;
                flip_p1_q      <= i_RESULT_SIGN_FLIP;
            end
        end
    end

    fadd_n40 #(
        .N   (N),
        .EW  (EW),
        .EWA (EA)
    ) u_fadd (
        .a_sign_i (prod_sign_p1_q),
        .a_exp_i  (prod_exp_p1_q),
        .a_frac_i (prod_frac_p1_q),
        .b_sign_i (cof1_sign_p1_q),
        .b_exp_i  (cof1_exp_p1_q),
        .b_frac_i (cof1_frac_p1_q),
        .s_sign_o (s_sign_d),
        .s_exp_o  (s_exp_d),
        .s_frac_o (s_frac_d)
    );

    // Stage B: capture the sum and forward side-band data on valid stage-A contents
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_p2_q       <= 1'b0;
            s_sign_p2_q    <= 1'b0;
            s_exp_p2_q     <= '0;
            s_frac_p2_q    <= '0;
            cof0_sign_p2_q <= 1'b0;
            cof0_exp_p2_q  <= '0;
            cof0_frac_p2_q <= '0;
            x_sign_p2_q    <= 1'b0;
            x_exp_p2_q     <= '0;
            x_frac_p2_q    <= '0;
            sel_p2_q       <= 1'b0;
            xz_p2_q        <= 1'b0;
            flip_p2_q      <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                s_sign_p2_q    <= s_sign_d;
                s_exp_p2_q     <= s_exp_d;
                s_frac_p2_q    <= s_frac_d;
                cof0_sign_p2_q <= cof0_sign_p1_q;
                cof0_exp_p2_q  <= cof0_exp_p1_q;
                cof0_frac_p2_q <= cof0_frac_p1_q;
                x_sign_p2_q    <= x_sign_p1_q;
                x_exp_p2_q     <= x_exp_p1_q;
                x_frac_p2_q    <= x_frac_p1_q;
                sel_p2_q       <= sel_p1_q;
                xz_p2_q        <= xz_p1_q;
                flip_p2_q      <= flip_p1_q;
            end
        end
    end

    assign o_valid            = vld_p2_q;
    assign o_sign_s           = s_sign_p2_q;
    assign o_exp_s            = s_exp_p2_q;
    assign o_frac_s           = s_frac_p2_q;
    assign o_reg_sign_cof0    = cof0_sign_p2_q;
    assign o_reg_exp_cof0     = cof0_exp_p2_q;
    assign o_reg_frac_cof0    = cof0_frac_p2_q;
    assign o_sign_XorD        = x_sign_p2_q;
    assign o_exp_XorD         = x_exp_p2_q;
    assign o_frac_XorD        = x_frac_p2_q;
    assign o_sel_DorX         = sel_p2_q;
    assign o_X_ZERO_CAL       = xz_p2_q;
    assign o_RESULT_SIGN_FLIP = flip_p2_q;

endmodule
